rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4:1, N-bit mux datapath among four requesters.
- Picks one requester per transfer and drives the mux select.
- Captures the selected word into a registered output stage with a valid/ready handshake downstream.
- Sits between four independent producers and a single consumer port.

---
 rtl/rr_mux4_arbiter.sv | 98 +++++++++
 tb/tb_rr_mux4_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing a 4:1 N-bit mux among four requesters, with a registered valid/ready output stage.
// Define RR_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 highest).
module rr_mux4_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]   state;
  logic [1:0]   win;
  logic         any;
  logic         load;
  logic [N-1:0] win_data;

  assign any       = |req;
  assign load      = (state == IDLE) || out_ready;
  assign out_valid = (state == FULL);
  assign gnt       = (rst_n && load && any) ? (4'b0001 << win) : 4'b0000;

`ifdef RR_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
  end
`else
  logic [1:0] last;
  logic [1:0] base;
  logic [1:0] off;
  logic [6:0] req2;
  logic [3:0] rot;

  // Rotate req so the requester after 'last' lands at bit 0, then take the lowest set bit.
  always_comb begin
    base = last + 2'd1;
    req2 = {req[2:0], req};
    rot  = req2[base +: 4];
    off  = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (rot[j]) off = 2'(j);
    end
    win = base + off;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 2'd3;
    end else if (load && any) begin
      last <= win;
    end
  end
`endif

  always_comb begin
    win_data = d0;
    case (win)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  // Output stage: a refill in FULL with out_ready=1 consumes and captures at the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      sel   <= 2'd0;
    end else if (load) begin
      if (any) begin
        state <= FULL;
        out   <= win_data;
        sel   <= win;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed literal cases plus randomized traffic checked each cycle
// against a behavioural model. Honours RR_FIXED_PRIO_EN when defined.
module tb_rr_mux4_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [N-1:0] d [4];
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_ready;

  int errors = 0;
  int checks = 0;

`ifdef RR_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  rr_mux4_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d[0]),
    .d1        (d[1]),
    .d2        (d[2]),
    .d3        (d[3]),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: holding register, valid flag and the index of the last winner.
  bit           model_ok = 1'b0;
  bit           m_valid;
  logic [N-1:0] m_out;
  int           m_sel;
  int           m_last;

  function automatic int model_win(input logic [3:0] r, input int lst);
    if (FIXED) begin
      for (int i = 0; i < 4; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (r[(lst + k) % 4]) return (lst + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [3:0] model_gnt();
    if (!rst_n || req == 4'b0000) return 4'b0000;
    if (m_valid && !out_ready) return 4'b0000;
    return 4'(1 << model_win(req, m_last));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      model_ok = 1'b1;
      m_valid  = 1'b0;
      m_out    = '0;
      m_sel    = 0;
      m_last   = 3;
    end else if (!m_valid || out_ready) begin
      if (req != 4'b0000) begin
        m_last  = model_win(req, m_last);
        m_sel   = m_last;
        m_out   = d[m_last];
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_gnt", gnt, model_gnt());
      check("model_out_valid", out_valid, m_valid);
      check("model_out", out, m_out);
      check("model_sel", sel, m_sel);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int a, input int b, input int c, input int e);
    d[0] = 4'(a); d[1] = 4'(b); d[2] = 4'(c); d[3] = 4'(e);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    set_d(0, 0, 0, 0);

    // Reset then single request
    @(negedge clk);
    check("gnt_during_reset", gnt, 4'b0000);
    tick();
    req = 4'b0000;
    tick();
    check("reset_out", out, 0);
    check("reset_valid", out_valid, 0);
    check("reset_sel", sel, 0);
    rst_n = 1'b1; req = 4'b0100; d[2] = 4'h7;
    @(negedge clk);
    check("single_gnt", gnt, 4'b0100);
    tick();
    check("single_out", out, 4'h7);
    check("single_sel", sel, 2);
    check("single_valid", out_valid, 1);
    req = 4'b0000;
    @(negedge clk);
    check("single_gnt_off", gnt, 4'b0000);
    tick();
    check("single_drain_valid", out_valid, 0);
    check("single_hold_out", out, 4'h7);

    // Round-robin rotation from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 4'b1111; set_d(1, 2, 3, 4); out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_gnt", gnt, FIXED ? 4'b0001 : 4'(1 << (k % 4)));
      tick();
      check("rr_out", out, FIXED ? 1 : (k % 4) + 1);
      check("rr_valid", out_valid, 1);
    end

    // Back-pressure
    req = 4'b0010; d[1] = 4'hA;
    tick();
    check("bp_load_out", out, 4'hA);
    out_ready = 1'b0; req = 4'b0001; d[0] = 4'h5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_gnt", gnt, 4'b0000);
      check("bp_out", out, 4'hA);
      check("bp_sel", sel, 1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_gnt", gnt, 4'b0001);
    tick();
    check("bp_release_out", out, 4'h5);
    check("bp_release_sel", sel, 0);

    // Pointer wrap: 1001 from last=3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 4'b1001; d[0] = 4'h6; d[3] = 4'h9;
    @(negedge clk);
    check("wrap_gnt_first", gnt, 4'b0001);
    tick();
    @(negedge clk);
    check("wrap_gnt_second", gnt, FIXED ? 4'b0001 : 4'b1000);
    tick();
    check("wrap_out_second", out, FIXED ? 4'h6 : 4'h9);

    // Withdrawn request while full
    out_ready = 1'b0; req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("withdraw_gnt_held", gnt, 4'b0000);
      tick();
    end
    req = 4'b0000;
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("withdraw_gnt_consume", gnt, 4'b0000);
    tick();
    check("withdraw_valid", out_valid, 0);

    // Reset mid-transfer
    req = 4'b0001; d[0] = 4'hF;
    tick();
    check("mid_full_out", out, 4'hF);
    out_ready = 1'b0; req = 4'b0000; rst_n = 1'b0;
    tick();
    check("mid_reset_out", out, 0);
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_sel", sel, 0);
    rst_n = 1'b1; req = 4'b1111; set_d(1, 2, 3, 4);
    @(negedge clk);
    check("mid_first_gnt", gnt, 4'b0001);
    tick();

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(99) != 0);
      req       = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
